// File: rtl/alu_seq_ctrl_if.sv
// Control/handshake bundle between alu_seq_ctrl and its ALU/register-file datapath.
// master = the controller, slave = the instruction source and datapath.
interface alu_seq_ctrl_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [DATA_WIDTH-1:0]    instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     EQ;
  logic                     RegWrite;
  logic                     ALUsrc;
  logic                     ALUctrl;
  logic [DATA_WIDTH-1:0]    immOp;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    pc;
  logic                     busy;
  logic                     illegal;

  modport master (
    input  instr, instr_valid, EQ,
    output instr_ready, RegWrite, ALUsrc, ALUctrl, immOp, rs1, rs2, rd, pc, busy, illegal
  );

  modport slave (
    output instr, instr_valid, EQ,
    input  instr_ready, RegWrite, ALUsrc, ALUctrl, immOp, rs1, rs2, rd, pc, busy, illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Four-state (IDLE/DECODE/EXEC/WB) sequencer for ADD, ADDI and BNE; owns the PC.
// Define ALU_SEQ_CTRL_BEQ_EN to also decode BEQ; otherwise BEQ is illegal.
module alu_seq_ctrl #(
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  localparam logic [6:0]            OP_R    = 7'b0110011;
  localparam logic [6:0]            OP_I    = 7'b0010011;
  localparam logic [6:0]            OP_B    = 7'b1100011;
  localparam logic [DATA_WIDTH-1:0] PC_RST  = DATA_WIDTH'(RESET_PC);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(3'd4);

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [DATA_WIDTH-1:0]    pc_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                     alusrc_q, aluctrl_q, regwrite_q;
  logic                     wen_q, bne_q, beq_q, taken_q;
  logic                     ready_q, busy_q, illegal_q;

  logic [6:0]               opcode_s;
  logic [2:0]               funct3_s;
  logic [6:0]               funct7_s;
  logic [4:0]               rd_field_s;
  logic [DATA_WIDTH-1:0]    imm_i_s, imm_b_s, dec_imm_s;
  logic                     dec_legal_s, dec_wen_s, dec_src_s, dec_ctl_s;
  logic                     dec_bne_s, dec_beq_s;

  assign opcode_s   = instr_q[6:0];
  assign funct3_s   = instr_q[14:12];
  assign funct7_s   = instr_q[31:25];
  assign rd_field_s = instr_q[11:7];
  assign imm_i_s    = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_b_s    = {{(DATA_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                       instr_q[30:25], instr_q[11:8], 1'b0};

  // Instruction decode of the latched word.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_wen_s   = 1'b0;
    dec_src_s   = 1'b0;
    dec_ctl_s   = 1'b0;
    dec_bne_s   = 1'b0;
    dec_beq_s   = 1'b0;
    dec_imm_s   = {DATA_WIDTH{1'b0}};
    case (opcode_s)
      OP_R: begin
        if (funct3_s == 3'b000 && funct7_s == 7'b0000000) begin
          dec_legal_s = 1'b1;
          dec_wen_s   = (rd_field_s != 5'd0);
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OP_I: begin
        if (funct3_s == 3'b000) begin
          dec_legal_s = 1'b1;
          dec_wen_s   = (rd_field_s != 5'd0);
          dec_src_s   = 1'b1;
          dec_imm_s   = imm_i_s;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OP_B: begin
        if (funct3_s == 3'b001) begin
          dec_legal_s = 1'b1;
          dec_ctl_s   = 1'b1;
          dec_bne_s   = 1'b1;
          dec_imm_s   = imm_b_s;
`ifdef ALU_SEQ_CTRL_BEQ_EN
        end else if (funct3_s == 3'b000) begin
          dec_legal_s = 1'b1;
          dec_ctl_s   = 1'b1;
          dec_beq_s   = 1'b1;
          dec_imm_s   = imm_b_s;
`endif
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Next-state logic; instr_valid only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, datapath controls and PC; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= {DATA_WIDTH{1'b0}};
      pc_q       <= PC_RST;
      imm_q      <= {DATA_WIDTH{1'b0}};
      rs1_q      <= {ADDRESS_WIDTH{1'b0}};
      rs2_q      <= {ADDRESS_WIDTH{1'b0}};
      rd_q       <= {ADDRESS_WIDTH{1'b0}};
      alusrc_q   <= 1'b0;
      aluctrl_q  <= 1'b0;
      regwrite_q <= 1'b0;
      wen_q      <= 1'b0;
      bne_q      <= 1'b0;
      beq_q      <= 1'b0;
      taken_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == S_IDLE);
      busy_q     <= (state_d != S_IDLE);
      regwrite_q <= (state_d == S_WB) && wen_q;
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
          end
        end
        S_DECODE: begin
          rs1_q     <= ADDRESS_WIDTH'(instr_q[19:15]);
          rs2_q     <= ADDRESS_WIDTH'(instr_q[24:20]);
          rd_q      <= dec_legal_s ? ADDRESS_WIDTH'(rd_field_s) : {ADDRESS_WIDTH{1'b0}};
          alusrc_q  <= dec_src_s;
          aluctrl_q <= dec_ctl_s;
          imm_q     <= dec_imm_s;
          wen_q     <= dec_wen_s;
          bne_q     <= dec_bne_s;
          beq_q     <= dec_beq_s;
          if (!dec_legal_s) begin
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          taken_q <= (bne_q && !bus.EQ) || (beq_q && bus.EQ);
        end
        S_WB: begin
          pc_q <= taken_q ? (pc_q + imm_q) : (pc_q + PC_STEP);
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.RegWrite    = regwrite_q;
  assign bus.ALUsrc      = alusrc_q;
  assign bus.ALUctrl     = aluctrl_q;
  assign bus.immOp       = imm_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.pc          = pc_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with hand-computed expectations.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_seq_ctrl_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  alu_seq_ctrl #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .RESET_PC(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction from IDLE back to IDLE; optionally present the next word during WB.
  task automatic run(input string tag, input logic [31:0] w, input logic eq,
                     input logic [31:0] exp_pc, input logic exp_we,
                     input logic exp_src, input logic exp_ctl, input logic [31:0] exp_imm,
                     input logic [4:0] exp_rs1, input logic [4:0] exp_rs2, input logic [4:0] exp_rd,
                     input logic nv, input logic [31:0] nw);
    chk({tag, ".ready_idle"}, 32'(bus.instr_ready), 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    // DECODE: the latched word must not be replaced by later bus contents
    bus.instr_valid = 1'b0;
    bus.instr       = 32'hDEADBEEF;
    bus.EQ          = ~eq;
    chk({tag, ".ready_dec"}, 32'(bus.instr_ready), 32'd0);
    chk({tag, ".busy_dec"}, 32'(bus.busy), 32'd1);
    step();
    // EXEC
    bus.EQ = eq;
    chk({tag, ".we_exec"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, ".alusrc"}, 32'(bus.ALUsrc), 32'(exp_src));
    chk({tag, ".aluctrl"}, 32'(bus.ALUctrl), 32'(exp_ctl));
    chk({tag, ".imm"}, bus.immOp, exp_imm);
    chk({tag, ".rs1"}, 32'(bus.rs1), 32'(exp_rs1));
    chk({tag, ".rs2"}, 32'(bus.rs2), 32'(exp_rs2));
    chk({tag, ".rd"}, 32'(bus.rd), 32'(exp_rd));
    step();
    // WB
    bus.EQ = ~eq;
    if (nv) begin
      bus.instr       = nw;
      bus.instr_valid = 1'b1;
    end else begin
      bus.instr_valid = 1'b0;
    end
    chk({tag, ".we_wb"}, 32'(bus.RegWrite), 32'(exp_we));
    chk({tag, ".ready_wb"}, 32'(bus.instr_ready), 32'd0);
    step();
    // back in IDLE
    chk({tag, ".pc"}, bus.pc, exp_pc);
    chk({tag, ".we_idle"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  localparam logic [31:0] ADDI_X10 = 32'h00500513;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] ADD_X3   = 32'h002081B3;
  localparam logic [31:0] BNE_M8   = 32'hFE209CE3;
  localparam logic [31:0] BAD      = 32'hFFFFFFFF;
  localparam logic [31:0] BEQ_P8   = 32'h00000463;

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;
    bus.EQ          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.pc", bus.pc, 32'h0);
    chk("rst.we", 32'(bus.RegWrite), 32'd0);
    chk("rst.ready", 32'(bus.instr_ready), 32'd1);
    chk("rst.illegal", 32'(bus.illegal), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    step();
    chk("idle.hold", 32'(bus.busy), 32'd0);

    run("addi10", ADDI_X10, 1'b0, 32'h4, 1'b1, 1'b1, 1'b0, 32'h5, 5'd0, 5'd5, 5'd10, 1'b0, 32'h0);
    run("addi0", ADDI_X0, 1'b0, 32'h8, 1'b0, 1'b1, 1'b0, 32'h1, 5'd0, 5'd1, 5'd0, 1'b0, 32'h0);
    run("add1", ADD_X3, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, ADD_X3);
    chk("hs.ready_after_wb", 32'(bus.instr_ready), 32'd1);
    run("add2", ADD_X3, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
    run("bne_tk", BNE_M8, 1'b0, 32'h8, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 1'b0, 32'h0);
    run("addi_a", ADDI_X10, 1'b0, 32'hC, 1'b1, 1'b1, 1'b0, 32'h5, 5'd0, 5'd5, 5'd10, 1'b0, 32'h0);
    run("addi_b", ADDI_X10, 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h5, 5'd0, 5'd5, 5'd10, 1'b0, 32'h0);
    run("bne_nt", BNE_M8, 1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 1'b0, 32'h0);
    chk("pre.illegal", 32'(bus.illegal), 32'd0);
    run("bad", BAD, 1'b0, 32'h18, 1'b0, 1'b0, 1'b0, 32'h0, 5'd31, 5'd31, 5'd0, 1'b0, 32'h0);
    chk("bad.illegal", 32'(bus.illegal), 32'd1);
    run("addi_c", ADDI_X10, 1'b0, 32'h1C, 1'b1, 1'b1, 1'b0, 32'h5, 5'd0, 5'd5, 5'd10, 1'b0, 32'h0);
    chk("sticky.illegal", 32'(bus.illegal), 32'd1);

    // reset while an ADD is in EXEC
    bus.instr       = ADD_X3;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("rstx.busy_exec", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstx.pc", bus.pc, 32'h0);
    chk("rstx.busy", 32'(bus.busy), 32'd0);
    chk("rstx.we", 32'(bus.RegWrite), 32'd0);
    chk("rstx.ready", 32'(bus.instr_ready), 32'd1);
    chk("rstx.illegal", 32'(bus.illegal), 32'd0);
    step();
    chk("rstx.we2", 32'(bus.RegWrite), 32'd0);
    chk("rstx.pc2", bus.pc, 32'h0);

`ifdef ALU_SEQ_CTRL_BEQ_EN
    run("beq", BEQ_P8, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h8, 5'd0, 5'd0, 5'd8, 1'b0, 32'h0);
    chk("beq.illegal", 32'(bus.illegal), 32'd0);
`else
    run("beq", BEQ_P8, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    chk("beq.illegal", 32'(bus.illegal), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control unit that sequences the ALU/register-file datapath for one instruction at a time.
- Accepts 32-bit RV32 instruction words over a valid/ready handshake and decodes ADD, ADDI and BNE.
- Drives the datapath controls RegWrite, ALUsrc, ALUctrl, immOp, rs1, rs2 and rd, and samples the datapath's EQ flag.
- Owns the program counter and updates it on branch resolution.

Parameters:
- ADDRESS_WIDTH, 5, register address width
- DATA_WIDTH, 32, datapath and instruction width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous active-high reset
- instr  in  DATA_WIDTH  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  controller can accept an instruction
- EQ  in  1  ALU equality flag from the datapath (operands equal)
- RegWrite  out  1  register-file write enable
- ALUsrc  out  1  0 = register operand 2, 1 = immOp
- ALUctrl  out  1  0 = add, 1 = subtract
- immOp  out  DATA_WIDTH  sign-extended immediate
- rs1, rs2, rd  out  ADDRESS_WIDTH  register addresses
- pc  out  DATA_WIDTH  program counter
- busy  out  1  high in every state except IDLE
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; pc=RESET_PC.
  - All other outputs 0, including illegal; instr_ready is 1 in IDLE.
  - Reset in any state abandons the in-flight instruction: no write, no PC update.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE. Each state lasts one cycle, so throughput is 1 instruction per 4 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr and go to DECODE; otherwise stay in IDLE.
  - instr_ready=0 in all other states; instr is ignored there.
- DECODE registers the datapath controls, which are then held until the next DECODE:
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
  - ADD (opcode 0110011, funct3 000, funct7 0000000): ALUsrc=0, ALUctrl=0.
  - ADDI (opcode 0010011, funct3 000): ALUsrc=1, ALUctrl=0, immOp = sign-extended instr[31:20].
  - BNE (opcode 1100011, funct3 001): ALUsrc=0, ALUctrl=1, immOp = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - Any other encoding is illegal: set illegal=1 (sticky until reset) and force rd=0.
- EXEC: operands settle; sample EQ into an internal taken bit, taken = BNE & ~EQ.
- WB:
  - RegWrite=1 for exactly this one cycle, only for ADD/ADDI with rd != 0.
  - Writes to x0 are suppressed (RegWrite stays 0).
  - pc <= taken ? pc + immOp : pc + 4.
  - PC arithmetic is modulo 2^DATA_WIDTH (wrap-around allowed); illegal instructions advance pc by 4.
- RegWrite is 0 in every state other than WB.
- busy = (state != IDLE).
- A valid instruction presented in the cycle of WB's return to IDLE is accepted on the following cycle, when instr_ready=1; it is never dropped.

Optional Feature:
- Macro ALU_SEQ_CTRL_BEQ_EN.
- Defined: BEQ (opcode 1100011, funct3 000) is decoded with the same controls as BNE, with taken = EQ.
- Undefined: BEQ is decoded as illegal (illegal=1, no write, pc+4).

Test Plan:
- Reset check: hold rst 2 cycles -> pc=0, RegWrite=0, instr_ready=1, illegal=0, busy=0.
- ADDI x10,x0,5 (0x00500513) -> during DECODE..WB: rs1=0, rd=10, ALUsrc=1, immOp=5; RegWrite=1 only in cycle 3 after accept; pc 0->4; instr_ready back high in cycle 4.
- ADDI x0,x0,1 (0x00100013) -> RegWrite stays 0; pc 4->8.
- BNE x1,x2,-8 (0xFE209CE3) at pc=0x10 with EQ=0 in EXEC -> pc=0x08. Same instruction with EQ=1 -> pc=0x14. Both cases: ALUctrl=1, ALUsrc=0, RegWrite=0.
- Illegal word 0xFFFFFFFF -> illegal=1 and remains 1 across subsequent legal instructions until rst; pc+4.
- Assert rst during EXEC of an ADD -> next cycle state IDLE, pc=RESET_PC, no RegWrite pulse. Also check BEQ 0x00000463 with EQ=1: taken, pc+8 when ALU_SEQ_CTRL_BEQ_EN is defined; illegal=1 when undefined.
